input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 500000 (10 ms at 50 MHz), the number of stable cycles required to accept a key level change.
REQ-002 The block SHALL have parameter CNT_W, default 19, the debounce counter width; legal only if 2 <= DEB_CYCLES <= 2^CNT_W.
REQ-003 Port clk, input, 1, system clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1, reset; synchronous, active-low.
REQ-005 Port key_n, input, 1, raw asynchronous push-button, low = pressed, bouncing.
REQ-006 Port sw_w, input, 1, raw asynchronous slide-switch data bit.
REQ-007 Port step, output, 1, single-cycle clock-enable pulse, one per accepted press, for the downstream sequence detector.
REQ-008 Port w_out, output, 1, data bit captured with each step, held stable between steps.
REQ-009 Port key_level, output, 1, debounced key state, 1 = pressed.
REQ-010 Port press_cnt, output, 8, count of accepted presses.

Function
REQ-011 key_n and sw_w SHALL each pass through a 2-flop synchronizer; only the second-stage outputs (key_s, w_s) SHALL feed downstream logic; key_p = NOT key_s.
REQ-012 The FSM SHALL have exactly four states: IDLE, PRESS_WAIT, HELD, REL_WAIT.
REQ-013 IDLE: key_p=1 -> PRESS_WAIT, counter cleared to 0; otherwise stay.
REQ-014 PRESS_WAIT: key_p=0 -> IDLE with no step (bounce rejected); key_p=1 and counter = DEB_CYCLES-1 -> HELD; otherwise counter +1.
REQ-015 HELD: key_p=0 -> REL_WAIT, counter cleared to 0; otherwise stay.
REQ-016 REL_WAIT: key_p=1 -> HELD with no new step; key_p=0 and counter = DEB_CYCLES-1 -> IDLE; otherwise counter +1.
REQ-017 step SHALL be 1 for exactly the one cycle immediately following the edge on which the FSM moves PRESS_WAIT -> HELD, and 0 in every other cycle.
REQ-018 Latency: if edge k is the first edge to sample key_n low and key_n stays low, step SHALL be high in the cycle following edge k+2+DEB_CYCLES.
REQ-019 w_out SHALL load w_s on the same edge as the PRESS_WAIT -> HELD transition, so w_out is valid while step=1, and SHALL hold that value until the next such edge.
REQ-020 key_level SHALL be 1 in HELD and REL_WAIT, and 0 in IDLE and PRESS_WAIT.
REQ-021 press_cnt SHALL increment by 1 on the same edge that raises step, wrapping from 255 to 0.
REQ-022 A press held indefinitely SHALL produce exactly one step; there is no auto-repeat.
REQ-023 Changes on sw_w SHALL never generate step.

Reset
REQ-024 With rst=0 at a rising edge, the block SHALL set FSM=IDLE, counter=0, key synchronizer flops=1, w synchronizer flops=0, step=0, w_out=0, key_level=0, press_cnt=0.
REQ-025 Reset SHALL take priority over all other activity, including mid-debounce and mid-press.
REQ-026 If the key is still held when rst returns to 1, the block SHALL treat it as a new press and emit one step after full debounce.

Verification (DEB_CYCLES=4, CNT_W=3)
REQ-027 Clean press: key_n low from edge 10, sw_w=1 -> step=1 only in the cycle after edge 16, w_out=1, press_cnt=1, key_level=1.
REQ-028 Bounce: key_n low for 2 cycles, high for 3, then low -> no step from the first pulse; exactly one step, 6 edges after the final falling sample.
REQ-029 Release bounce: while HELD, key_n high for 2 cycles then low again -> FSM returns to HELD, no step, press_cnt unchanged.
REQ-030 Wrap: 256 clean press/release cycles -> press_cnt = 0 and exactly 256 single-cycle steps observed.
REQ-031 Reset mid-press: rst=0 for 1 cycle while in PRESS_WAIT with the key held -> all outputs 0 the next cycle; one step follows 4 cycles after the FSM re-enters PRESS_WAIT.
REQ-032 Data capture: sw_w toggles every cycle during PRESS_WAIT -> w_out equals the w_s value present at the HELD-entry edge, and w_out stays constant until the next step.

Source files
------------

// File: rtl/input_conditioner.sv
// Push-button and slide-switch conditioner: synchronizes both raw inputs,
// debounces the key in both directions, and emits one clock-enable pulse per
// accepted press together with the switch bit captured on that edge.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | key released and stable, waiting for a press
// PRESS_WAIT | key seen pressed, counting stable cycles before acceptance
// HELD       | press accepted, key still down
// REL_WAIT   | key seen released, counting stable cycles before idling
//
// DEB_CYCLES must satisfy 2 <= DEB_CYCLES <= 2**CNT_W so that the terminal
// count DEB_CYCLES-1 fits in the counter.
module input_conditioner #(
   parameter int DEB_CYCLES = 500000,
   parameter int CNT_W      = 19
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_n,
   input  logic       sw_w,
   output logic       step,
   output logic       w_out,
   output logic       key_level,
   output logic [7:0] press_cnt
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_WAIT = 2'd1,
      HELD       = 2'd2,
      REL_WAIT   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic       key_s1_q, key_s_q;
   logic       w_s1_q, w_s_q;
   logic       key_p;

   state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic       step_q, step_d;
   logic       w_out_q, w_out_d;
   logic       key_level_q, key_level_d;
   logic [7:0] press_cnt_q, press_cnt_d;

   // Two-flop synchronizers; key idles released (1), switch idles 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         key_s1_q <= 1'b1;
         key_s_q  <= 1'b1;
         w_s1_q   <= 1'b0;
         w_s_q    <= 1'b0;
      end else begin
         key_s1_q <= key_n;
         key_s_q  <= key_s1_q;
         w_s1_q   <= sw_w;
         w_s_q    <= w_s1_q;
      end
   end

   assign key_p = ~key_s_q;

   // Next-state, counter and registered-output logic for the debounce FSM.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      step_d      = 1'b0;
      w_out_d     = w_out_q;
      press_cnt_d = press_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (key_p) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!key_p) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = HELD;
               step_d      = 1'b1;
               w_out_d     = w_s_q;
               press_cnt_d = press_cnt_q + 8'd1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         HELD: begin
            if (!key_p) begin
               state_d = REL_WAIT;
               cnt_d   = '0;
            end
         end
         REL_WAIT: begin
            if (key_p) begin
               state_d = HELD;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
      key_level_d = (state_d == HELD) || (state_d == REL_WAIT);
   end

   // FSM state, counter and outputs; reset wins over any debounce in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         step_q      <= 1'b0;
         w_out_q     <= 1'b0;
         key_level_q <= 1'b0;
         press_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         step_q      <= step_d;
         w_out_q     <= w_out_d;
         key_level_q <= key_level_d;
         press_cnt_q <= press_cnt_d;
      end
   end

   assign step      = step_q;
   assign w_out     = w_out_q;
   assign key_level = key_level_q;
   assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEB_CYCLES=4, CNT_W=3. A run-length
// debounce model predicts every output each cycle; directed scenarios add
// hand-computed checks on step timing, captured data and press counts.
module tb_input_conditioner;

   localparam int DEB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_n;
   logic       sw_w;
   logic       step;
   logic       w_out;
   logic       key_level;
   logic [7:0] press_cnt;

   int n_cmp  = 0;
   int n_fail = 0;
   int edge_n = 0;
   int n_steps = 0;
   int last_step_edge = -1;

   input_conditioner #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_n     (key_n),
      .sw_w      (sw_w),
      .step      (step),
      .w_out     (w_out),
      .key_level (key_level),
      .press_cnt (press_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", nm, edge_n, act, exp);
      end
   endtask

   // Model: the debounced level flips once the synchronized key has differed
   // from it for DEB+1 consecutive samples; a flip to pressed is a step.
   logic m_k1, m_k2, m_w1, m_w2;
   bit   m_lvl;
   int   m_run;
   bit   m_kp;
   bit   exp_step, exp_w;
   logic [7:0] exp_cnt;

   always @(posedge clk) begin
      if (!rst) begin
         m_k1 = 1'b1; m_k2 = 1'b1; m_w1 = 1'b0; m_w2 = 1'b0;
         m_lvl = 0; m_run = 0;
         exp_step = 0; exp_w = 0; exp_cnt = 8'd0;
      end else begin
         m_kp = ~m_k2;
         exp_step = 0;
         if (m_kp != m_lvl) begin
            m_run++;
            if (m_run == DEB + 1) begin
               m_lvl = m_kp;
               m_run = 0;
               if (m_kp) begin
                  exp_step = 1;
                  exp_w    = m_w2;
                  exp_cnt  = exp_cnt + 8'd1;
               end
            end
         end else begin
            m_run = 0;
         end
         m_k2 = m_k1; m_k1 = key_n;
         m_w2 = m_w1; m_w1 = sw_w;
      end
   end

   always @(negedge clk) begin
      if (edge_n >= 1) begin
         chk("step", {31'd0, step}, {31'd0, exp_step});
         chk("w_out", {31'd0, w_out}, {31'd0, exp_w});
         chk("key_level", {31'd0, key_level}, {31'd0, m_lvl});
         chk("press_cnt", {24'd0, press_cnt}, {24'd0, exp_cnt});
         if (step === 1'b1) begin
            n_steps++;
            last_step_edge = edge_n;
         end
      end
   end

   // Advance to the falling edge that follows rising edge n.
   task automatic to_neg(input int n);
      while (edge_n < n) @(negedge clk);
   endtask

   int base;
   int t;

   initial begin
      rst = 1'b0; key_n = 1'b1; sw_w = 1'b0;

      to_neg(1);
      chk("rst_step", {31'd0, step}, 32'd0);
      chk("rst_w_out", {31'd0, w_out}, 32'd0);
      chk("rst_key_level", {31'd0, key_level}, 32'd0);
      chk("rst_press_cnt", {24'd0, press_cnt}, 32'd0);
      to_neg(2);
      rst = 1'b1; sw_w = 1'b1;

      // Clean press: first low sample at edge 10, step after edge 16.
      to_neg(9);
      key_n = 1'b0;
      to_neg(20);
      chk("clean_step_edge", last_step_edge, 32'd16);
      chk("clean_n_steps", n_steps, 32'd1);
      chk("clean_press_cnt", {24'd0, press_cnt}, 32'd1);
      chk("clean_w_out", {31'd0, w_out}, 32'd1);
      chk("clean_key_level", {31'd0, key_level}, 32'd1);
      key_n = 1'b1;
      to_neg(35);
      chk("release_key_level", {31'd0, key_level}, 32'd0);

      // Bounce: 2 low, 3 high, then low from edge 41; step after edge 47.
      key_n = 1'b0;
      to_neg(37);
      key_n = 1'b1;
      to_neg(40);
      key_n = 1'b0;
      to_neg(55);
      chk("bounce_step_edge", last_step_edge, 32'd47);
      chk("bounce_n_steps", n_steps, 32'd2);
      chk("bounce_press_cnt", {24'd0, press_cnt}, 32'd2);

      // Release bounce: 2 high samples while held, back to held.
      key_n = 1'b1;
      to_neg(57);
      key_n = 1'b0;
      to_neg(75);
      chk("relb_n_steps", n_steps, 32'd2);
      chk("relb_press_cnt", {24'd0, press_cnt}, 32'd2);
      chk("relb_key_level", {31'd0, key_level}, 32'd1);
      key_n = 1'b1;
      to_neg(90);
      chk("relb_released", {31'd0, key_level}, 32'd0);

      // Data capture: sw_w = i&1 at edge 91+i; held entry at edge 97 uses
      // the switch value sampled at edge 95, i.e. 0. Long hold, one step.
      for (int i = 0; i < 12; i++) begin
         to_neg(90 + i);
         sw_w = (i % 2 == 1);
         key_n = 1'b0;
      end
      to_neg(140);
      chk("cap_step_edge", last_step_edge, 32'd97);
      chk("cap_w_out", {31'd0, w_out}, 32'd0);
      chk("hold_n_steps", n_steps, 32'd3);
      chk("hold_press_cnt", {24'd0, press_cnt}, 32'd3);
      key_n = 1'b1;

      // Reset mid-press: press at edge 161, reset edge 165, step after 172.
      to_neg(160);
      key_n = 1'b0;
      to_neg(164);
      rst = 1'b0;
      to_neg(165);
      rst = 1'b1;
      chk("mid_rst_step", {31'd0, step}, 32'd0);
      chk("mid_rst_w_out", {31'd0, w_out}, 32'd0);
      chk("mid_rst_key_level", {31'd0, key_level}, 32'd0);
      chk("mid_rst_press_cnt", {24'd0, press_cnt}, 32'd0);
      to_neg(180);
      chk("mid_rst_step_edge", last_step_edge, 32'd172);
      chk("mid_rst_press_cnt_after", {24'd0, press_cnt}, 32'd1);
      key_n = 1'b1;

      // Switch activity alone never steps.
      base = n_steps;
      for (int i = 0; i < 10; i++) begin
         to_neg(edge_n + 1);
         sw_w = ~sw_w;
      end
      to_neg(edge_n + 5);
      chk("sw_only_no_step", n_steps - base, 32'd0);

      // Wrap: reset, then 256 clean press/release cycles.
      rst = 1'b0;
      to_neg(edge_n + 1);
      rst = 1'b1;
      base = n_steps;
      for (int i = 0; i < 256; i++) begin
         key_n = 1'b0;
         t = edge_n;
         to_neg(t + 8);
         key_n = 1'b1;
         t = edge_n;
         to_neg(t + 8);
      end
      to_neg(edge_n + 10);
      chk("wrap_n_steps", n_steps - base, 32'd256);
      chk("wrap_press_cnt", {24'd0, press_cnt}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
